// File: rtl/pc_unit.sv
// pc_unit: program counter with trap/redirect/return priority, alignment check
// and circular return-address stack. Rev 1.0
`default_nettype none

module pc_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned     INSTR_BYTES  = 4,
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         enable_i,
  input  logic                         trap_i,
  input  logic                         redirect_i,
  input  logic [XLEN-1:0]              redirect_pc_i,
  input  logic                         call_i,
  input  logic                         ret_i,
  output logic [XLEN-1:0]              curr_pc_o,
  output logic [XLEN-1:0]              pc_plus_o,
  output logic                         misaligned_o,
  output logic                         ras_underflow_o,
  output logic [$clog2(RAS_DEPTH):0]   ras_count_o
);

  localparam int unsigned ALIGN_BITS = $clog2(INSTR_BYTES);
  localparam int unsigned PTR_W      = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W      = PTR_W + 1;
  localparam logic [CNT_W-1:0] RAS_FULL = CNT_W'(RAS_DEPTH);

  logic [XLEN-1:0]  pc_q, pc_d;
  logic             mis_q, mis_d;
  logic             uf_q, uf_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  ras_q [RAS_DEPTH];
  logic             push;
  logic             target_misaligned;
  logic [PTR_W-1:0] ptr_dec;

  assign pc_plus_o = pc_q + XLEN'(INSTR_BYTES);
  assign ptr_dec   = ptr_q - PTR_W'(1);

  // With single-byte instructions every target is aligned.
  generate
    if (ALIGN_BITS == 0) begin : g_no_align
      assign target_misaligned = 1'b0;
    end else begin : g_align
      assign target_misaligned = |redirect_pc_i[ALIGN_BITS-1:0];
    end
  endgenerate

  always_comb begin
    pc_d  = pc_q;
    mis_d = 1'b0;
    uf_d  = 1'b0;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    push  = 1'b0;
    if (trap_i) begin
      pc_d = TRAP_VECTOR;
    end else if (!enable_i) begin
      pc_d = pc_q;
    end else if (redirect_i) begin
      if (target_misaligned) begin
        pc_d  = TRAP_VECTOR;
        mis_d = 1'b1;
      end else begin
        pc_d = redirect_pc_i;
        if (call_i) begin
          push  = 1'b1;
          ptr_d = ptr_q + PTR_W'(1);
          if (cnt_q != RAS_FULL) cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end else if (ret_i) begin
      if (cnt_q != '0) begin
        pc_d  = ras_q[ptr_dec];
        ptr_d = ptr_dec;
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        pc_d = pc_plus_o;
        uf_d = 1'b1;
      end
    end else begin
      pc_d = pc_plus_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q  <= RESET_VECTOR;
      mis_q <= 1'b0;
      uf_q  <= 1'b0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      mis_q <= mis_d;
      uf_q  <= uf_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Stack storage needs no reset; entries are only read when counted valid.
  always_ff @(posedge clk_i) begin
    if (push) ras_q[ptr_q] <= pc_plus_o;
  end

  assign curr_pc_o       = pc_q;
  assign misaligned_o    = mis_q;
  assign ras_underflow_o = uf_q;
  assign ras_count_o     = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed-vector self-checking bench for pc_unit.
`default_nettype none

module tb_pc_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        enable_i;
  logic        trap_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        call_i;
  logic        ret_i;
  logic [31:0] curr_pc_o;
  logic [31:0] pc_plus_o;
  logic        misaligned_o;
  logic        ras_underflow_o;
  logic [2:0]  ras_count_o;

  int n_checks = 0;
  int n_errors = 0;

  pc_unit dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .enable_i        (enable_i),
    .trap_i          (trap_i),
    .redirect_i      (redirect_i),
    .redirect_pc_i   (redirect_pc_i),
    .call_i          (call_i),
    .ret_i           (ret_i),
    .curr_pc_o       (curr_pc_o),
    .pc_plus_o       (pc_plus_o),
    .misaligned_o    (misaligned_o),
    .ras_underflow_o (ras_underflow_o),
    .ras_count_o     (ras_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    trap_i = 0; redirect_i = 0; call_i = 0; ret_i = 0; redirect_pc_i = '0;
  endtask

  task automatic state(input string tag, input logic [31:0] pc, input logic [31:0] cnt,
                       input logic mis, input logic uf);
    check({tag, ".pc"},  curr_pc_o, pc);
    check({tag, ".cnt"}, 32'(ras_count_o), cnt);
    check({tag, ".mis"}, 32'(misaligned_o), 32'(mis));
    check({tag, ".uf"},  32'(ras_underflow_o), 32'(uf));
  endtask

  initial begin
    rst_ni = 0; enable_i = 0;
    idle();
    tick(); tick();
    state("reset", 32'h0, 0, 0, 0);

    rst_ni = 1; enable_i = 1;
    tick(); state("seq1", 32'h4, 0, 0, 0);
    tick(); state("seq2", 32'h8, 0, 0, 0);
    check("pc_plus", pc_plus_o, 32'hC);

    enable_i = 0;
    for (int i = 0; i < 3; i++) begin
      tick(); check("stall.pc", curr_pc_o, 32'h8);
    end
    trap_i = 1;
    tick(); state("trap", 32'h100, 0, 0, 0);
    trap_i = 0; enable_i = 1;

    redirect_i = 1; redirect_pc_i = 32'h10;
    tick(); check("to10", curr_pc_o, 32'h10);
    call_i = 1; redirect_pc_i = 32'h200;
    tick(); state("call1", 32'h200, 1, 0, 0);
    idle();
    tick(); check("adv", curr_pc_o, 32'h204);
    redirect_i = 1; call_i = 1; redirect_pc_i = 32'h300;
    tick(); state("call2", 32'h300, 2, 0, 0);
    idle(); ret_i = 1;
    tick(); state("ret1", 32'h208, 1, 0, 0);
    tick(); state("ret2", 32'h14, 0, 0, 0);

    idle(); redirect_i = 1; redirect_pc_i = 32'h0;
    tick(); check("to0", curr_pc_o, 32'h0);
    call_i = 1;
    for (int i = 0; i < 5; i++) begin
      redirect_pc_i = 32'h10 * (i + 1);
      tick();
      state("ovf", 32'h10 * (i + 1), (i < 4) ? i + 1 : 4, 0, 0);
    end
    idle(); ret_i = 1;
    tick(); state("pop44", 32'h44, 3, 0, 0);
    tick(); state("pop34", 32'h34, 2, 0, 0);
    tick(); state("pop24", 32'h24, 1, 0, 0);
    tick(); state("pop14", 32'h14, 0, 0, 0);
    tick(); state("under", 32'h18, 0, 0, 1);
    idle();
    tick(); state("under_end", 32'h1C, 0, 0, 0);

    redirect_i = 1; call_i = 1; redirect_pc_i = 32'h60;
    tick(); state("call60", 32'h60, 1, 0, 0);
    redirect_pc_i = 32'h202;
    tick(); state("misal", 32'h100, 1, 1, 0);
    idle(); enable_i = 0;
    tick(); state("misal_stall", 32'h100, 1, 0, 0);
    enable_i = 1;
    tick(); state("misal_end", 32'h104, 1, 0, 0);

    redirect_i = 1; redirect_pc_i = 32'hFFFF_FFFC;
    tick(); check("wrap.pc", curr_pc_o, 32'hFFFF_FFFC);
    check("wrap.plus", pc_plus_o, 32'h0);
    idle();
    tick(); check("wrap.next", curr_pc_o, 32'h0);

    redirect_i = 1; redirect_pc_i = 32'h40; ret_i = 1;
    tick(); state("prio", 32'h40, 1, 0, 0);
    idle(); ret_i = 1;
    tick(); state("pop20", 32'h20, 0, 0, 0);

    idle(); redirect_i = 1; call_i = 1; redirect_pc_i = 32'h80;
    tick(); state("precall", 32'h80, 1, 0, 0);
    idle();
    #2 rst_ni = 0;
    #1 state("async_rst", 32'h0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
